// File: rtl/axi_stride_rd_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_stride_rd_gen_if
// Brief    : AXI read-address and read-data channel bundle for the generator.
// Revision : 1.0
// ============================================================================
interface axi_stride_rd_gen_if #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;

    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_WIDTH-1:0]      m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );
endinterface
`default_nettype wire

// File: rtl/axi_stride_rd_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_stride_rd_gen
// Brief    : Issues strided AXI read bursts and checks the returning R beats.
// Revision : 1.0
// ============================================================================
module axi_stride_rd_gen #(
    parameter int ADDR_BITS           = 16,
    parameter int BURST_LEN_WIDTH     = 8,
    parameter int TID_WIDTH           = 8,
    parameter int DATA_WIDTH          = 8,
    parameter int LOG_MAX_OUTSTANDING = 3,
    parameter int CNT_WIDTH           = 16
) (
    input  wire logic                           clk,
    input  wire logic                           resetN,
    input  wire logic                           cfg_start,
    input  wire logic [ADDR_BITS-1:0]           cfg_base,
    input  wire logic [ADDR_BITS-1:0]           cfg_stride,
    input  wire logic [CNT_WIDTH-1:0]           cfg_count,
    input  wire logic [BURST_LEN_WIDTH-1:0]     cfg_len,
    input  wire logic [TID_WIDTH-1:0]           cfg_id,
    input  wire logic [CNT_WIDTH-1:0]           cfg_gap,
    input  wire logic [LOG_MAX_OUTSTANDING:0]   cfg_maxOutstanding,
    axi_stride_rd_gen_if.master                 bus,
    output logic                                busy,
    output logic                                done,
    output logic [2:0]                          errorCode,
    output logic [CNT_WIDTH-1:0]                stat_cycles,
    output logic [CNT_WIDTH-1:0]                stat_beats
);

    localparam int c_OUT_W = LOG_MAX_OUTSTANDING + 1;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_GAP   = 3'd2;
    localparam logic [2:0] c_DRAIN = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam logic [CNT_WIDTH-1:0]       c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_OUT_W-1:0]         c_OUT_ONE = {{(c_OUT_W-1){1'b0}}, 1'b1};
    localparam logic [BURST_LEN_WIDTH-1:0] c_LEN_ONE = {{(BURST_LEN_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]                 r_state;
    logic [2:0]                 w_next_state;

    logic [ADDR_BITS-1:0]       r_addr;
    logic [ADDR_BITS-1:0]       r_stride;
    logic [CNT_WIDTH-1:0]       r_count;
    logic [CNT_WIDTH-1:0]       r_gap;
    logic [BURST_LEN_WIDTH-1:0] r_len;
    logic [TID_WIDTH-1:0]       r_id;
    logic [c_OUT_W-1:0]         r_limit;

    logic [CNT_WIDTH-1:0]       r_issued;
    logic [CNT_WIDTH-1:0]       r_gap_cnt;
    logic [c_OUT_W-1:0]         r_outstanding;
    logic [BURST_LEN_WIDTH-1:0] r_beat_cnt;
    logic [2:0]                 r_error;
    logic [CNT_WIDTH-1:0]       r_stat_cycles;
    logic [CNT_WIDTH-1:0]       r_stat_beats;
    logic                       r_cyc_run;

    logic                       w_ar_valid;
    logic                       w_r_ready;
    logic                       w_start;
    logic                       w_ar_fire;
    logic                       w_r_fire;
    logic                       w_expected_beat;
    logic                       w_burst_end;
    logic                       w_last_issue;
    logic                       w_final_last;
    logic [DATA_WIDTH-1:0]      w_r_data_unused;

    assign w_start         = cfg_start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_ar_fire       = w_ar_valid && bus.m_ar_ready;
    assign w_r_fire        = bus.m_r_valid && w_r_ready;
    // Beats arriving with nothing outstanding are flagged but never close a burst.
    assign w_expected_beat = w_r_fire && (r_outstanding != '0);
    assign w_burst_end     = w_expected_beat && bus.m_r_last;
    assign w_last_issue    = (r_issued + c_CNT_ONE) == r_count;
    assign w_final_last    = w_burst_end && (r_outstanding == c_OUT_ONE) && !w_ar_fire
                             && (r_issued == r_count);
    assign w_r_data_unused = bus.m_r_data;

    // ------------------------------------------------------------------ state register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE, c_DONE: begin
                if (cfg_start) begin
                    w_next_state = (cfg_count == '0) ? c_DONE : c_ISSUE;
                end
            end
            c_ISSUE: begin
                if (w_ar_fire) begin
                    if (w_last_issue) begin
                        w_next_state = c_DRAIN;
                    end else if (r_gap != '0) begin
                        w_next_state = c_GAP;
                    end else begin
                        w_next_state = c_ISSUE;
                    end
                end
            end
            c_GAP: begin
                if (r_gap_cnt == (r_gap - c_CNT_ONE)) begin
                    w_next_state = c_ISSUE;
                end
            end
            c_DRAIN: begin
                if (r_outstanding == '0) begin
                    w_next_state = c_DONE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        w_ar_valid = 1'b0;
        w_r_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            c_ISSUE: begin
                w_ar_valid = r_outstanding < r_limit;
                w_r_ready  = 1'b1;
                busy       = 1'b1;
            end
            c_GAP, c_DRAIN: begin
                w_r_ready = 1'b1;
                busy      = 1'b1;
            end
            c_DONE: begin
                w_r_ready = 1'b1;
                done      = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.m_ar_valid = w_ar_valid;
    assign bus.m_ar_addr  = r_addr;
    assign bus.m_ar_len   = r_len;
    assign bus.m_ar_id    = r_id;
    assign bus.m_r_ready  = w_r_ready;

    assign errorCode   = r_error;
    assign stat_cycles = r_stat_cycles;
    assign stat_beats  = r_stat_beats;

    // ------------------------------------------------------------------ datapath
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_addr        <= '0;
            r_stride      <= '0;
            r_count       <= '0;
            r_gap         <= '0;
            r_len         <= '0;
            r_id          <= '0;
            r_limit       <= '0;
            r_issued      <= '0;
            r_gap_cnt     <= '0;
            r_outstanding <= '0;
            r_beat_cnt    <= '0;
            r_error       <= '0;
            r_stat_cycles <= '0;
            r_stat_beats  <= '0;
            r_cyc_run     <= 1'b0;
        end else if (w_start) begin
            r_addr        <= cfg_base;
            r_stride      <= cfg_stride;
            r_count       <= cfg_count;
            r_gap         <= cfg_gap;
            r_len         <= cfg_len;
            r_id          <= cfg_id;
            r_limit       <= (cfg_maxOutstanding == '0) ? c_OUT_ONE : cfg_maxOutstanding;
            r_issued      <= '0;
            r_gap_cnt     <= '0;
            r_outstanding <= '0;
            r_beat_cnt    <= '0;
            r_error       <= '0;
            r_stat_cycles <= '0;
            r_stat_beats  <= '0;
            r_cyc_run     <= 1'b0;
        end else begin
            if (w_ar_fire) begin
                r_addr    <= r_addr + r_stride;
                r_issued  <= r_issued + c_CNT_ONE;
                r_gap_cnt <= '0;
            end else if (r_state == c_GAP) begin
                r_gap_cnt <= r_gap_cnt + c_CNT_ONE;
            end

            case ({w_ar_fire, w_burst_end})
                2'b10:   r_outstanding <= r_outstanding + c_OUT_ONE;
                2'b01:   r_outstanding <= r_outstanding - c_OUT_ONE;
                default: ;
            endcase

            if (w_expected_beat) begin
                if (bus.m_r_last) begin
                    r_beat_cnt <= '0;
                    if (r_beat_cnt != r_len) begin
                        r_error[0] <= 1'b1;
                    end
                end else begin
                    r_beat_cnt <= r_beat_cnt + c_LEN_ONE;
                end
            end

            if (w_r_fire) begin
                if (bus.m_r_id != r_id) begin
                    r_error[1] <= 1'b1;
                end
                if (r_outstanding == '0) begin
                    r_error[2] <= 1'b1;
                end
                if (r_stat_beats != '1) begin
                    r_stat_beats <= r_stat_beats + c_CNT_ONE;
                end
            end

            // Cycle window opens after the first AR and closes on the rlast that empties the run.
            if (w_ar_fire && (r_issued == '0)) begin
                r_cyc_run <= 1'b1;
            end else if (w_final_last) begin
                r_cyc_run <= 1'b0;
            end

            if (r_cyc_run && (r_state != c_DONE) && (r_stat_cycles != '1)) begin
                r_stat_cycles <= r_stat_cycles + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stride_rd_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stride_rd_gen
// Brief    : Directed and randomized bench with a reactive AXI read slave.
// Revision : 1.0
// ============================================================================
module tb_axi_stride_rd_gen;

    localparam int AW   = 16;
    localparam int LW   = 8;
    localparam int IW   = 8;
    localparam int DW   = 8;
    localparam int LOGO = 3;
    localparam int CW   = 16;

    logic            clk = 1'b0;
    logic            resetN = 1'b0;
    logic            cfg_start = 1'b0;
    logic [AW-1:0]   cfg_base = '0;
    logic [AW-1:0]   cfg_stride = '0;
    logic [CW-1:0]   cfg_count = '0;
    logic [LW-1:0]   cfg_len = '0;
    logic [IW-1:0]   cfg_id = '0;
    logic [CW-1:0]   cfg_gap = '0;
    logic [LOGO:0]   cfg_maxOutstanding = '0;
    logic            busy;
    logic            done;
    logic [2:0]      errorCode;
    logic [CW-1:0]   stat_cycles;
    logic [CW-1:0]   stat_beats;

    axi_stride_rd_gen_if #(
        .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW), .DATA_WIDTH(DW)
    ) bus ();

    axi_stride_rd_gen #(
        .ADDR_BITS(AW), .BURST_LEN_WIDTH(LW), .TID_WIDTH(IW), .DATA_WIDTH(DW),
        .LOG_MAX_OUTSTANDING(LOGO), .CNT_WIDTH(CW)
    ) dut (
        .clk                (clk),
        .resetN             (resetN),
        .cfg_start          (cfg_start),
        .cfg_base           (cfg_base),
        .cfg_stride         (cfg_stride),
        .cfg_count          (cfg_count),
        .cfg_len            (cfg_len),
        .cfg_id             (cfg_id),
        .cfg_gap            (cfg_gap),
        .cfg_maxOutstanding (cfg_maxOutstanding),
        .bus                (bus),
        .busy               (busy),
        .done               (done),
        .errorCode          (errorCode),
        .stat_cycles        (stat_cycles),
        .stat_beats         (stat_beats)
    );

    always #5 clk = ~clk;

    // Reference run description
    logic [AW-1:0] m_base, m_stride;
    logic [CW-1:0] m_count, m_gap;
    logic [LW-1:0] m_len;
    logic [IW-1:0] m_id;
    int            m_lim;

    // Slave knobs
    int            ar_pct = 100, r_pct = 100, hold_until = 0, early_last = 0;
    logic [IW-1:0] rid_val = '0;
    bit            inj_after_final = 1'b0;

    // Observations
    logic [AW-1:0] ar_log[$];
    int            pending[$];
    int            cyc = 0, beat_idx, out_model, t_first_ar, t_last, prev_ar_cyc;
    int            ars_at_first_last, stab_viol, out_viol, hdr_viol, gap_viol;
    bit            got_first_last, prev_pend, inj_beat, slv_last;
    logic [AW-1:0] prev_addr;

    int            errors = 0, checks = 0;

    task automatic clear_logs();
        ar_log.delete();
        pending.delete();
        beat_idx = 0; out_model = 0; t_first_ar = 0; t_last = 0; prev_ar_cyc = 0;
        ars_at_first_last = 0; stab_viol = 0; out_viol = 0; hdr_viol = 0; gap_viol = 0;
        got_first_last = 1'b0; prev_pend = 1'b0; inj_beat = 1'b0;
    endtask

    // Reactive slave: decides at each falling edge what the next rising edge will accept.
    initial begin
        bus.m_ar_ready = 1'b0;
        bus.m_r_valid  = 1'b0;
        bus.m_r_data   = '0;
        bus.m_r_last   = 1'b0;
        bus.m_r_id     = '0;
        clear_logs();
        forever begin
            @(negedge clk);
            cyc++;
            if (!resetN) begin
                pending.delete();
                prev_pend = 1'b0; inj_beat = 1'b0; out_model = 0; beat_idx = 0;
                bus.m_ar_ready = 1'b0; bus.m_r_valid = 1'b0; bus.m_r_last = 1'b0;
                continue;
            end
            bus.m_r_valid = 1'b0;
            bus.m_r_last  = 1'b0;
            if (inj_beat) begin
                inj_beat = 1'b0;
                bus.m_r_valid = 1'b1; bus.m_r_last = 1'b1; bus.m_r_id = rid_val;
            end else if (pending.size() > 0 && cyc >= hold_until && $urandom_range(99) < r_pct) begin
                slv_last = (beat_idx + 1 == pending[0]) || (beat_idx + 1 == early_last);
                bus.m_r_valid = 1'b1; bus.m_r_last = slv_last; bus.m_r_id = rid_val;
                bus.m_r_data  = DW'($urandom);
                if (bus.m_r_ready) begin
                    if (slv_last) begin
                        void'(pending.pop_front());
                        beat_idx = 0; out_model--; t_last = cyc;
                        if (!got_first_last) begin
                            got_first_last = 1'b1;
                            ars_at_first_last = ar_log.size();
                        end
                        if (inj_after_final && pending.size() == 0 && ar_log.size() == int'(m_count))
                            inj_beat = 1'b1;
                    end else begin
                        beat_idx++;
                    end
                end
            end
            if (prev_pend && !(bus.m_ar_valid === 1'b1 && bus.m_ar_addr === prev_addr)) stab_viol++;
            bus.m_ar_ready = ($urandom_range(99) < ar_pct);
            if (bus.m_ar_valid && bus.m_ar_ready) begin
                if (bus.m_ar_len !== m_len || bus.m_ar_id !== m_id) hdr_viol++;
                if (ar_log.size() > 0 && (cyc - prev_ar_cyc) < int'(m_gap) + 1) gap_viol++;
                if (ar_log.size() == 0) t_first_ar = cyc;
                prev_ar_cyc = cyc;
                ar_log.push_back(bus.m_ar_addr);
                pending.push_back(int'(m_len) + 1);
                out_model++;
                if (out_model > m_lim) out_viol++;
            end
            prev_pend = bus.m_ar_valid && !bus.m_ar_ready;
            prev_addr = bus.m_ar_addr;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [AW-1:0] b, input logic [AW-1:0] s,
                             input logic [CW-1:0] c, input logic [LW-1:0] l,
                             input logic [IW-1:0] id, input logic [CW-1:0] g,
                             input logic [LOGO:0] mo);
        m_base = b; m_stride = s; m_count = c; m_len = l; m_id = id; m_gap = g;
        m_lim  = (mo == '0) ? 1 : int'(mo);
        rid_val = id; early_last = 0; inj_after_final = 1'b0; hold_until = 0;
        cfg_base = b; cfg_stride = s; cfg_count = c; cfg_len = l; cfg_id = id;
        cfg_gap = g; cfg_maxOutstanding = mo;
        clear_logs();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    task automatic check_run(input logic [2:0] exp_err, input int exp_beats);
        logic [AW-1:0] a;
        int            n;
        a = m_base;
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("error_code", {29'd0, errorCode}, {29'd0, exp_err});
        check("stat_beats", {16'd0, stat_beats}, exp_beats);
        check("ar_count", ar_log.size(), int'(m_count));
        n = (ar_log.size() < int'(m_count)) ? ar_log.size() : int'(m_count);
        for (int i = 0; i < n; i++) begin
            check("ar_addr", {16'd0, ar_log[i]}, {16'd0, a});
            a = a + m_stride;
        end
        check("stat_cycles", {16'd0, stat_cycles}, (m_count == '0) ? 0 : (t_last - t_first_ar));
        check("ar_stable", stab_viol, 0);
        check("outstanding_limit", out_viol, 0);
        check("ar_len_id", hdr_viol, 0);
        check("gap_spacing", gap_viol, 0);
    endtask

    initial begin
        int n;
        resetN = 1'b0;
        tick(); tick();
        check("rst_ar_valid", {31'd0, bus.m_ar_valid}, 32'd0);
        check("rst_r_ready", {31'd0, bus.m_r_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {29'd0, errorCode}, 32'd0);
        check("rst_stat_cycles", {16'd0, stat_cycles}, 32'd0);
        check("rst_stat_beats", {16'd0, stat_beats}, 32'd0);
        resetN = 1'b1;
        tick();

        // Always-ready slave, single-beat bursts
        ar_pct = 100; r_pct = 100;
        start_run(16'h5940, 16'd3, 16'd4, 8'd0, 8'h11, 16'd0, 4'd7);
        wait_done(200);
        check_run(3'b000, 4);

        // Address wrap with gaps, maxOutstanding=0 treated as 1
        start_run(16'hFFFE, 16'd3, 16'd3, 8'd1, 8'h22, 16'd2, 4'd0);
        wait_done(200);
        check_run(3'b000, 6);

        // Zero-count run goes straight to DONE
        start_run(16'h1000, 16'd4, 16'd0, 8'd0, 8'h01, 16'd0, 4'd3);
        tick();
        check("zero_count_done", {31'd0, done}, 32'd1);
        check_run(3'b000, 0);

        // Withheld R data limits issue to maxOutstanding; late start and cfg changes ignored
        ar_pct = 50;
        start_run(16'h0200, 16'h0040, 16'd5, 8'd1, 8'h33, 16'd0, 4'd2);
        hold_until = cyc + 50;
        tick(); tick();
        cfg_base = 16'hAAAA; cfg_count = 16'd1; cfg_stride = 16'd1; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        wait_done(600);
        check("ars_before_first_last", ars_at_first_last, 2);
        check_run(3'b000, 10);
        ar_pct = 100;

        // Early rlast on beat 2 of a 4-beat burst
        start_run(16'h3000, 16'h0100, 16'd3, 8'd3, 8'h44, 16'd1, 4'd4);
        early_last = 2;
        wait_done(300);
        check_run(3'b001, 6);

        // Wrong rid, then an unsolicited beat once every burst has closed
        start_run(16'h4000, 16'h0010, 16'd2, 8'd1, 8'h05, 16'd0, 4'd7);
        rid_val = 8'h06; inj_after_final = 1'b1;
        wait_done(300);
        check_run(3'b110, 5);

        // Reset while issuing with three bursts outstanding
        start_run(16'h5000, 16'h0020, 16'd5, 8'd0, 8'h07, 16'd0, 4'd7);
        hold_until = 1 << 30;
        n = 0;
        while (ar_log.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        ar_pct = 0;
        tick();
        check("pre_rst_issuing", {30'd0, busy, bus.m_ar_valid}, 32'd3);
        resetN = 1'b0;
        #1;
        check("mid_rst_ar_valid", {31'd0, bus.m_ar_valid}, 32'd0);
        check("mid_rst_r_ready", {31'd0, bus.m_r_ready}, 32'd0);
        check("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("mid_rst_error", {29'd0, errorCode}, 32'd0);
        check("mid_rst_stats", {stat_cycles, stat_beats}, 32'd0);
        tick();
        resetN = 1'b1;
        ar_pct = 100;
        tick();
        start_run(16'h1234, 16'h0010, 16'd3, 8'd2, 8'h09, 16'd0, 4'd3);
        wait_done(300);
        check_run(3'b000, 9);

        // Randomized runs against the reference model
        for (int k = 0; k < 6; k++) begin
            ar_pct = $urandom_range(100, 30);
            r_pct  = $urandom_range(100, 30);
            start_run(AW'($urandom), AW'($urandom), CW'($urandom_range(8, 1)),
                      LW'($urandom_range(3, 0)), IW'($urandom), CW'($urandom_range(3, 0)),
                      (LOGO+1)'($urandom_range(7, 0)));
            wait_done(2000);
            check_run(3'b000, int'(m_count) * (int'(m_len) + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_stride_rd_gen.md
AXI_STRIDE_RD_GEN -- requirements
Module: axi_stride_rd_gen

Interface
REQ-001 Parameter ADDR_BITS, 16, AR address width.
REQ-002 Parameter BURST_LEN_WIDTH, 8, AR length width.
REQ-003 Parameter TID_WIDTH, 8, transaction ID width.
REQ-004 Parameter DATA_WIDTH, 8, R data width.
REQ-005 Parameter LOG_MAX_OUTSTANDING, 3, outstanding-counter width minus one.
REQ-006 Parameter CNT_WIDTH, 16, request, gap and statistics counter width.
REQ-007 Ports, in order (name, direction, width, meaning):
- clk in 1: single clock, rising edge.
- resetN in 1: asynchronous, active-low reset.
- cfg_start in 1: one-cycle start pulse, sampled only in IDLE or DONE.
- cfg_base in ADDR_BITS: first request address.
- cfg_stride in ADDR_BITS: address increment per request.
- cfg_count in CNT_WIDTH: number of requests; 0 means go straight to DONE.
- cfg_len in BURST_LEN_WIDTH: AXI arlen; beats per burst = cfg_len+1.
- cfg_id in TID_WIDTH: arid to drive; also the expected rid.
- cfg_gap in CNT_WIDTH: idle cycles after each AR handshake.
- cfg_maxOutstanding in LOG_MAX_OUTSTANDING+1: limit on outstanding bursts; 0 is treated as 1.
- m_ar_valid, m_ar_ready, m_ar_addr, m_ar_len, m_ar_id: AXI AR master channel.
- m_r_valid, m_r_ready, m_r_data, m_r_last, m_r_id: AXI R master channel.
- busy out 1: FSM is not in IDLE or DONE.
- done out 1: FSM is in DONE.
- errorCode out 3: sticky error flags. [0] last-mismatch, [1] ID mismatch, [2] unexpected beat.
- stat_cycles out CNT_WIDTH: cycles from the first AR handshake to the final rlast.
- stat_beats out CNT_WIDTH: total R beats accepted.

Function
REQ-008 FSM states are IDLE, ISSUE, GAP, DRAIN, DONE.
REQ-009 IDLE/DONE with cfg_start: latch all cfg_* inputs, clear counters, stats and errorCode; next state is ISSUE, or DONE if cfg_count=0.
REQ-010 ISSUE: m_ar_valid=1 only when outstanding < limit; once asserted, valid and payload are held stable until m_ar_ready.
REQ-011 On AR handshake:
- issued increments.
- Address advances by stride, modulo 2^ADDR_BITS (wrap, no error).
- Next state is DRAIN if issued reaches count, else GAP if gap>0, else ISSUE.
REQ-012 GAP: counts gap cycles, then returns to ISSUE; m_ar_valid=0 throughout.
REQ-013 DRAIN: m_ar_valid=0; moves to DONE in the cycle after outstanding reaches 0.
REQ-014 m_ar_len = latched cfg_len; m_ar_id = latched cfg_id.
REQ-015 m_r_ready=1 in all states except IDLE.
REQ-016 outstanding: +1 on AR handshake, -1 on an R beat with m_r_last. Both in the same cycle leaves it unchanged.
REQ-017 A per-burst beat counter resets on every accepted rlast. rlast arriving on any beat other than cfg_len+1 sets errorCode[0]. The counter and outstanding still update as if the burst had ended.
REQ-018 Accepted beat with m_r_id different from the latched id sets errorCode[1].
REQ-019 Beat accepted while outstanding=0 sets errorCode[2]; the beat is counted and outstanding stays 0.
REQ-020 stat_beats increments on every accepted beat and saturates at all-ones.
REQ-021 stat_cycles counts from the cycle after the first AR handshake up to and including the final rlast, saturating; it freezes in DONE.
REQ-022 cfg_* changes while busy have no effect; cfg_start while busy is ignored.
REQ-023 m_r_data is not checked.

Reset
REQ-024 resetN=0 asynchronously forces:
- state IDLE; m_ar_valid=0, m_r_ready=0, busy=0, done=0;
- errorCode=0, stat_cycles=0, stat_beats=0, all internal counters 0.
REQ-025 Reset mid-burst abandons all outstanding bursts with no error. Behaviour resumes from IDLE on the first clock edge after deassertion.

Verification
REQ-026 Zero-delay slave; base=0x5940, stride=3, count=4, len=0, gap=0, maxOut=7 -> ARs 0x5940, 0x5943, 0x5946, 0x5949; stat_beats=4; done=1; errorCode=0.
REQ-027 base=0xFFFE, stride=3, count=3 -> addresses 0xFFFE, 0x0001, 0x0004.
REQ-028 maxOut=2, slave withholds R for 50 cycles, count=5 -> exactly 2 ARs issued before the first rlast; m_ar_valid stays stable under ready=0.
REQ-029 len=3, slave asserts rlast on beat 2 -> errorCode=3'b001; FSM still reaches DONE.
REQ-030 Slave returns rid=6 with cfg_id=5 -> errorCode[1]=1. Unsolicited beat in DRAIN after all bursts close -> errorCode[2]=1.
REQ-031 resetN pulsed low during ISSUE with 3 outstanding -> all outputs at reset values in the same cycle; a new cfg_start then runs cleanly.
